// File: rtl/dso_calib_pipe_if.sv
// rtl/dso_calib_pipe_if.sv - config write port and sample in/out handshake bundle for dso_calib_pipe
interface dso_calib_pipe_if #(
    parameter int DW  = 8,
    parameter int GW  = 8,
    parameter int CHW = 2
);
    localparam int CW = (DW > GW) ? DW : GW;

    logic           cfg_we;
    logic           cfg_sel;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_data;

    logic           in_vld;
    logic           in_rdy;
    logic [CHW-1:0] in_ch;
    logic [DW-1:0]  in_raw;

    logic           out_vld;
    logic           out_rdy;
    logic [CHW-1:0] out_ch;
    logic [DW-1:0]  out_smpl;
    logic           out_sat;

    modport master (
        output cfg_we, cfg_sel, cfg_ch, cfg_data,
        output in_vld, in_ch, in_raw, out_rdy,
        input  in_rdy, out_vld, out_ch, out_smpl, out_sat
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_ch, cfg_data,
        input  in_vld, in_ch, in_raw, out_rdy,
        output in_rdy, out_vld, out_ch, out_smpl, out_sat
    );
endinterface

// File: rtl/dso_calib_pipe.sv
// rtl/dso_calib_pipe.sv - two-stage per-channel offset/gain sample calibrator with saturation
module dso_calib_pipe #(
    parameter int DW  = 8,
    parameter int GW  = 8,
    parameter int NCH = 3,
    parameter int CHW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dso_calib_pipe_if.slave  bus
);
    localparam int              NREG    = 2 ** CHW;
    localparam int              PW      = DW + GW;
    localparam logic [CHW:0]    NCH_L   = (CHW + 1)'(NCH);
    localparam logic [GW-1:0]   G_UNITY = {1'b1, {(GW - 1){1'b0}}};
    localparam logic [PW-1:0]   P_MAX   = {1'b0, {(PW - 1){1'b1}}};

    // Sized to the full index space so out-of-range channels read a harmless constant.
    logic [DW-1:0]  off_q  [NREG];
    logic [GW-1:0]  gain_q [NREG];

    logic           s1_vld_q;
    logic [DW-1:0]  s1_s_q;
    logic [GW-1:0]  s1_g_q;
    logic [CHW-1:0] s1_ch_q;
    logic           s1_sat_q;

    logic           s2_vld_q;
    logic [DW-1:0]  s2_smpl_q;
    logic [CHW-1:0] s2_ch_q;
    logic           s2_sat_q;

    logic                 en;
    logic                 in_ok;
    logic                 cfg_ok;
    logic signed [DW+1:0] sum;
    logic [DW-1:0]        s1_s_d;
    logic                 s1_sat_d;
    logic [PW-1:0]        prod;
    logic [PW-1:0]        prod_c;
    logic [DW-1:0]        s2_smpl_d;
    logic                 s2_sat_d;

    always_comb begin
        en     = ~s2_vld_q | bus.out_rdy;
        in_ok  = bus.in_vld & ({1'b0, bus.in_ch} < NCH_L);
        cfg_ok = bus.cfg_we & ({1'b0, bus.cfg_ch} < NCH_L);

        sum = $signed({2'b00, bus.in_raw})
            + $signed({{2{off_q[bus.in_ch][DW-1]}}, off_q[bus.in_ch]});
        s1_s_d   = sum[DW-1:0];
        s1_sat_d = 1'b0;
        if (sum[DW+1]) begin
            s1_s_d   = '0;
            s1_sat_d = 1'b1;
        end else if (sum[DW]) begin
            s1_s_d   = '1;
            s1_sat_d = 1'b1;
        end

        prod     = PW'(s1_s_q) * PW'(s1_g_q);
        prod_c   = prod;
        s2_sat_d = s1_sat_q;
        if (prod[PW-1]) begin
            prod_c   = P_MAX;
            s2_sat_d = 1'b1;
        end
        s2_smpl_d = prod_c[PW-2:GW-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                off_q[i]  <= '0;
                gain_q[i] <= G_UNITY;
            end
            s1_vld_q  <= 1'b0;
            s1_s_q    <= '0;
            s1_g_q    <= '0;
            s1_ch_q   <= '0;
            s1_sat_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_smpl_q <= '0;
            s2_ch_q   <= '0;
            s2_sat_q  <= 1'b0;
        end else begin
            if (cfg_ok) begin
                if (bus.cfg_sel) begin
                    gain_q[bus.cfg_ch] <= bus.cfg_data[GW-1:0];
                end else begin
                    off_q[bus.cfg_ch] <= bus.cfg_data[DW-1:0];
                end
            end
            // Stage 1 reads coefficients before this edge's write lands, so a colliding write is not seen.
            if (en) begin
                s1_vld_q <= in_ok;
                if (in_ok) begin
                    s1_s_q   <= s1_s_d;
                    s1_g_q   <= gain_q[bus.in_ch];
                    s1_ch_q  <= bus.in_ch;
                    s1_sat_q <= s1_sat_d;
                end
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_smpl_q <= s2_smpl_d;
                    s2_ch_q   <= s1_ch_q;
                    s2_sat_q  <= s2_sat_d;
                end
            end
        end
    end

    assign bus.in_rdy   = en;
    assign bus.out_vld  = s2_vld_q;
    assign bus.out_ch   = s2_ch_q;
    assign bus.out_smpl = s2_smpl_q;
    assign bus.out_sat  = s2_sat_q;
endmodule

// File: tb/tb_dso_calib_pipe.sv
// tb/tb_dso_calib_pipe.sv - directed-vector bench for dso_calib_pipe
module tb_dso_calib_pipe;
    logic clk = 1'b0;
    logic rst_n;

    dso_calib_pipe_if #(.DW(8), .GW(8), .CHW(2)) bus ();

    dso_calib_pipe #(.DW(8), .GW(8), .NCH(3), .CHW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];
    logic        trk_en    = 1'b0;
    logic        hold_prev = 1'b0;
    logic [10:0] prev_out  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle; inputs only move just after the rising edge.
    always @(negedge clk) begin
        if (hold_prev && rst_n)
            check("hold_stable", {bus.out_ch, bus.out_smpl, bus.out_sat}, prev_out);
        if (trk_en)
            check("in_rdy_en", bus.in_rdy, !bus.out_vld || bus.out_rdy);
        if (rst_n && bus.out_vld && bus.out_rdy)
            got_q.push_back({bus.out_ch, bus.out_smpl, bus.out_sat});
        hold_prev = rst_n && bus.out_vld && !bus.out_rdy;
        prev_out  = {bus.out_ch, bus.out_smpl, bus.out_sat};
    end

    task automatic cfg(input logic sel, input logic [1:0] ch, input logic [7:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_ch   = ch;
        bus.cfg_data = d;
        @(posedge clk); #1;
        bus.cfg_we   = 1'b0;
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] raw,
                        input logic [7:0] es, input logic esat, input bit has_out);
        bit acc = 1'b0;
        bus.in_vld = 1'b1;
        bus.in_ch  = ch;
        bus.in_raw = raw;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_rdy;
            @(posedge clk); #1;
        end
        bus.in_vld = 1'b0;
        check("send_accept", acc, 1);
        if (acc && has_out) exp_q.push_back({ch, es, esat});
    endtask

    task automatic drain(input string tag);
        bus.out_rdy = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_sel  = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_data = '0;
        bus.in_vld   = 1'b0;
        bus.in_ch    = '0;
        bus.in_raw   = '0;
        bus.out_rdy  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_out_vld", bus.out_vld, 0);
        check("rst_in_rdy", bus.in_rdy, 1);
        check("rst_out_smpl", bus.out_smpl, 0);
        check("rst_out_ch", bus.out_ch, 0);
        check("rst_out_sat", bus.out_sat, 0);

        send(2'd0, 8'h40, 8'h40, 1'b0, 1'b1);
        check("lat_stage1_vld", bus.out_vld, 0);
        @(posedge clk); #1;
        check("lat_stage2_vld", bus.out_vld, 1);
        check("lat_smpl", bus.out_smpl, 8'h40);
        check("lat_ch", bus.out_ch, 0);
        check("lat_sat", bus.out_sat, 0);
        drain("defaults");

        cfg(1'b0, 2'd1, 8'h20);
        cfg(1'b1, 2'd1, 8'h80);
        send(2'd1, 8'hF0, 8'hFF, 1'b1, 1'b1);
        cfg(1'b0, 2'd1, 8'hD0);
        send(2'd1, 8'h10, 8'h00, 1'b1, 1'b1);
        drain("offset_clamp");

        cfg(1'b0, 2'd2, 8'hD0);
        cfg(1'b1, 2'd2, 8'hC0);
        send(2'd2, 8'h90, 8'h90, 1'b0, 1'b1);
        cfg(1'b0, 2'd2, 8'h00);
        cfg(1'b1, 2'd2, 8'hFF);
        send(2'd2, 8'hC0, 8'hFF, 1'b1, 1'b1);
        send(2'd2, 8'h10, 8'h1F, 1'b0, 1'b1);
        drain("gain");

        trk_en = 1'b1;
        fork
            begin
                for (int v = 1; v <= 4; v++)
                    send(2'd0, 8'(v), 8'(v), 1'b0, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_rdy = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_rdy = 1'b1;
            end
        join
        drain("backpressure");
        trk_en = 1'b0;

        check("coll_in_rdy", bus.in_rdy, 1);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 1'b1;
        bus.cfg_ch   = 2'd0;
        bus.cfg_data = 8'h40;
        bus.in_vld   = 1'b1;
        bus.in_ch    = 2'd0;
        bus.in_raw   = 8'h40;
        @(posedge clk); #1;
        bus.cfg_we   = 1'b0;
        @(posedge clk); #1;
        bus.in_vld   = 1'b0;
        exp_q.push_back({2'd0, 8'h40, 1'b0});
        exp_q.push_back({2'd0, 8'h20, 1'b0});
        drain("collision");

        send(2'd3, 8'h55, 8'h00, 1'b0, 1'b0);
        cfg(1'b1, 2'd3, 8'h00);
        cfg(1'b0, 2'd3, 8'h7F);
        send(2'd0, 8'h40, 8'h20, 1'b0, 1'b1);
        send(2'd1, 8'h10, 8'h00, 1'b1, 1'b1);
        send(2'd2, 8'h10, 8'h1F, 1'b0, 1'b1);
        drain("bad_channel");

        bus.out_rdy = 1'b0;
        send(2'd0, 8'h40, 8'h00, 1'b0, 1'b0);
        send(2'd0, 8'h41, 8'h00, 1'b0, 1'b0);
        check("inflight_vld", bus.out_vld, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_rdy = 1'b1;
        check("midrst_out_vld", bus.out_vld, 0);
        check("midrst_in_rdy", bus.in_rdy, 1);
        check("midrst_out_smpl", bus.out_smpl, 0);
        check("midrst_out_ch", bus.out_ch, 0);
        check("midrst_out_sat", bus.out_sat, 0);
        send(2'd1, 8'h40, 8'h40, 1'b0, 1'b1);
        send(2'd0, 8'h40, 8'h40, 1'b0, 1'b1);
        send(2'd2, 8'h10, 8'h10, 1'b0, 1'b1);
        drain("reset_flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
